seat_alloc_ctrl: RTL and testbench
==================================

// Module: seat_alloc_ctrl
// PURPOSE
//  Sequential seat-allocation controller. On start it latches seven 4-bit candidate scores
//  (c1..c7) and an eligibility threshold (n). It then fills up to three seats (r1..r3) with
//  candidate indices, highest eligible score first. It sits in front of the seat-result
//  logic and replaces a one-shot combinational evaluation with one shared comparator.
//  The comparator is scanned over the candidates across a fixed number of cycles.
// PARAMETERS
//  SCORE_W       4   width of n and c1..c7
//  TIE_HIGH_IDX  0   0: equal scores resolve to the lower candidate index; 1: to the higher index
// PORTS
//  clk     in   1        rising-edge clock
//  rst_n   in   1        synchronous reset, active-low
//  start   in   1        request allocation; sampled only in IDLE
//  n       in   SCORE_W  eligibility threshold; candidate eligible iff score >= n (unsigned)
//  c1..c7  in   SCORE_W  candidate scores
//  busy    out  1        high from the cycle after an accepted start until done
//  done    out  1        one-cycle pulse; r1..r3 valid from this cycle
//  r1..r3  out  4        seat k holds candidate index 1..7; 0 = seat unfilled
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, r1=r2=r3=0; latched data cleared.
//    Reset applied mid-operation aborts the allocation. No done is produced.
//  - States: IDLE -> SCAN -> COMMIT -> (SCAN | FIN) -> IDLE.
//  - IDLE: on start=1 at edge 0, latch n and c1..c7, clear r1..r3, set seat=1, cand=1, go to SCAN.
//    busy=1 from cycle 1. Input changes after edge 0 have no effect.
//  - SCAN: 7 cycles, one candidate per cycle (cand 1..7).
//    - A candidate is skipped if it is ineligible or already placed in an earlier seat.
//    - Otherwise it replaces the running best if score > best. On equal score it replaces
//      the best only when TIE_HIGH_IDX=1.
//  - COMMIT (1 cycle): if a best exists, write it to r<seat>.
//    - Go to SCAN for the next seat if seat<3; else go to FIN.
//    - If no best exists, leave r<seat>=0 and go to FIN. Later seats stay 0.
//  - Seat k occupies cycles 8k-7..8k (7 SCAN cycles + 1 COMMIT cycle).
//    Full run: done at cycle 25. Run with an empty pass p: done at cycle 8p+1.
//  - FIN: done=1 and busy=0 in the same cycle; return to IDLE.
//    r1..r3 hold their values until the next accepted start or reset.
//  - start while busy or in FIN: ignored (not queued).
//  - Back-to-back: start=1 in the cycle after done is accepted normally.
//  - n=0: all candidates eligible. Score 0 with n=0 is eligible and can win.
//  - Comparisons are unsigned on SCORE_W bits. Indices are always 3'd1..3'd7, zero-extended to 4 bits.
// CONFIGURATION
//  SEAT_ALLOC_ABORT_EN defined:
//    - Adds input port abort (1 bit).
//    - abort=1 at an edge in SCAN/COMMIT/FIN: next state is IDLE; busy=0, r1..r3=0; no done pulse.
//    - abort is ignored in IDLE. abort together with start in IDLE: start wins.
//  SEAT_ALLOC_ABORT_EN undefined:
//    - abort port does not exist. An accepted allocation always runs to done unless reset.
// TESTING
//  1. n=7, c1..c7={15,3,7,15,7,4,7}, start at cycle 0 -> done at cycle 25; r1=1, r2=4, r3=3.
//  2. Same scores, n=15 -> done at cycle 25; r1=1, r2=4, r3=0.
//  3. n=1, all c=0 -> done at cycle 9; r1=r2=r3=0; busy high cycles 1..8.
//  4. Case 1 with TIE_HIGH_IDX=1 -> r1=4, r2=1, r3=7.
//  5. Case 1; pulse start at cycle 5, change c1 to 0 at cycle 3 -> second start ignored;
//     result unchanged (r1=1, r2=4, r3=3).
//  6. Case 1; rst_n=0 at cycle 12 -> busy=0, r=0 next edge; no done; fresh start then completes normally.
//     With SEAT_ALLOC_ABORT_EN defined, abort at cycle 12 gives the same response.

Source files
------------

// File: rtl/seat_alloc_ctrl.sv
// seat_alloc_ctrl
//   Sequential seat-allocation controller. On an accepted start it latches the
//   threshold n and seven candidate scores, then fills up to three seats with
//   candidate indices, highest eligible score first. A single shared comparator
//   is scanned over the candidates, one per cycle.
//   Each seat takes 7 SCAN cycles plus 1 COMMIT cycle. A full run pulses done
//   in cycle 25. A run that ends on an empty seat p pulses done in cycle 8p+1.
//
// Parameters
//   SCORE_W       width of n and c1..c7
//   TIE_HIGH_IDX  0: equal scores go to the lower index; 1: to the higher index
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start    allocation request; sampled only in IDLE
//   abort    (SEAT_ALLOC_ABORT_EN only) cancels a running allocation
//   n        eligibility threshold (score >= n, unsigned)
//   c1..c7   candidate scores
//   busy     high while scanning or committing
//   done     one-cycle pulse; r1..r3 are valid from this cycle
//   r1..r3   seat results: candidate index 1..7, or 0 when the seat is unfilled
//
// Configuration macro
//   SEAT_ALLOC_ABORT_EN  adds the abort input
module seat_alloc_ctrl #(
    parameter int SCORE_W      = 4,
    parameter int TIE_HIGH_IDX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef SEAT_ALLOC_ABORT_EN
    input  logic               abort,
`endif
    input  logic [SCORE_W-1:0] n,
    input  logic [SCORE_W-1:0] c1,
    input  logic [SCORE_W-1:0] c2,
    input  logic [SCORE_W-1:0] c3,
    input  logic [SCORE_W-1:0] c4,
    input  logic [SCORE_W-1:0] c5,
    input  logic [SCORE_W-1:0] c6,
    input  logic [SCORE_W-1:0] c7,
    output logic               busy,
    output logic               done,
    output logic [3:0]         r1,
    output logic [3:0]         r2,
    output logic [3:0]         r3
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t             state_q, state_d;

    logic [SCORE_W-1:0] n_q;
    logic [SCORE_W-1:0] c_q [7];
    logic [2:0]         cand_q;
    logic [1:0]         seat_q;
    logic [2:0]         best_idx_q;
    logic [SCORE_W-1:0] best_score_q;
    logic [3:0]         r1_q, r2_q, r3_q;

    logic [SCORE_W-1:0] cur_score;
    logic [3:0]         cand_ext;
    logic               placed;
    logic               eligible;
    logic               better;
    logic               take;
    logic               abort_hit;

`ifdef SEAT_ALLOC_ABORT_EN
    assign abort_hit = abort && (state_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Shared comparator: score of the candidate under scan versus the running best.
    always_comb begin
        cur_score = '0;
        case (cand_q)
            3'd1:    cur_score = c_q[0];
            3'd2:    cur_score = c_q[1];
            3'd3:    cur_score = c_q[2];
            3'd4:    cur_score = c_q[3];
            3'd5:    cur_score = c_q[4];
            3'd6:    cur_score = c_q[5];
            3'd7:    cur_score = c_q[6];
            default: cur_score = '0;
        endcase
    end

    assign cand_ext = {1'b0, cand_q};
    // Seats still unfilled hold 0, which never matches an index in 1..7.
    assign placed   = (cand_ext == r1_q) || (cand_ext == r2_q) || (cand_ext == r3_q);
    assign eligible = (cur_score >= n_q);
    assign better   = (best_idx_q == 3'd0) ||
                      (cur_score > best_score_q) ||
                      ((TIE_HIGH_IDX != 0) && (cur_score == best_score_q));
    assign take     = eligible && !placed && better;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (cand_q == 3'd7) state_d = COMMIT;
            end
            COMMIT: begin
                busy = 1'b1;
                if ((best_idx_q != 3'd0) && (seat_q != 2'd3)) state_d = SCAN;
                else                                           state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_hit) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort_hit) begin
            n_q          <= '0;
            for (int unsigned i = 0; i < 7; i++) c_q[i] <= '0;
            cand_q       <= '0;
            seat_q       <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            r1_q         <= '0;
            r2_q         <= '0;
            r3_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q          <= n;
                        c_q[0]       <= c1;
                        c_q[1]       <= c2;
                        c_q[2]       <= c3;
                        c_q[3]       <= c4;
                        c_q[4]       <= c5;
                        c_q[5]       <= c6;
                        c_q[6]       <= c7;
                        cand_q       <= 3'd1;
                        seat_q       <= 2'd1;
                        best_idx_q   <= '0;
                        best_score_q <= '0;
                        r1_q         <= '0;
                        r2_q         <= '0;
                        r3_q         <= '0;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best_idx_q   <= cand_q;
                        best_score_q <= cur_score;
                    end
                    cand_q <= cand_q + 3'd1;
                end
                COMMIT: begin
                    if (best_idx_q != 3'd0) begin
                        case (seat_q)
                            2'd1:    r1_q <= {1'b0, best_idx_q};
                            2'd2:    r2_q <= {1'b0, best_idx_q};
                            2'd3:    r3_q <= {1'b0, best_idx_q};
                            default: ;
                        endcase
                    end
                    best_idx_q   <= '0;
                    best_score_q <= '0;
                    seat_q       <= seat_q + 2'd1;
                    cand_q       <= 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign r1 = r1_q;
    assign r2 = r2_q;
    assign r3 = r3_q;

endmodule

// File: tb/tb_seat_alloc_ctrl.sv
// Bench for seat_alloc_ctrl: two instances (low-index and high-index tie rule)
// share all stimulus. Expected seat results are queued when a start is issued
// and compared when the expected done cycle arrives.
module tb_seat_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
`ifdef SEAT_ALLOC_ABORT_EN
    logic       abort;
`endif
    logic [3:0] n, c1, c2, c3, c4, c5, c6, c7;
    logic       busy_lo, done_lo, busy_hi, done_hi;
    logic [3:0] r1_lo, r2_lo, r3_lo, r1_hi, r2_hi, r3_hi;

    always #5 clk = ~clk;

    seat_alloc_ctrl #(.SCORE_W(4), .TIE_HIGH_IDX(0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SEAT_ALLOC_ABORT_EN
        .abort(abort),
`endif
        .n(n), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
        .busy(busy_lo), .done(done_lo), .r1(r1_lo), .r2(r2_lo), .r3(r3_lo)
    );

    seat_alloc_ctrl #(.SCORE_W(4), .TIE_HIGH_IDX(1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SEAT_ALLOC_ABORT_EN
        .abort(abort),
`endif
        .n(n), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
        .busy(busy_hi), .done(done_hi), .r1(r1_hi), .r2(r2_hi), .r3(r3_hi)
    );

    typedef struct {
        logic [3:0]       n;
        logic [6:0][3:0]  c;
        int               lo1, lo2, lo3;
        int               hi1, hi2, hi3;
        int               done_cyc;
    } vec_t;

    vec_t tbl[8];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input int nn, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7,
                                input int l1, input int l2, input int l3,
                                input int h1, input int h2, input int h3, input int dc);
        vec_t v;
        v.n = nn[3:0];
        v.c[0] = a1[3:0]; v.c[1] = a2[3:0]; v.c[2] = a3[3:0]; v.c[3] = a4[3:0];
        v.c[4] = a5[3:0]; v.c[5] = a6[3:0]; v.c[6] = a7[3:0];
        v.lo1 = l1; v.lo2 = l2; v.lo3 = l3;
        v.hi1 = h1; v.hi2 = h2; v.hi3 = h3;
        v.done_cyc = dc;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_r_zero(input string tag);
        chk({tag, " r1_lo"}, r1_lo, 0); chk({tag, " r2_lo"}, r2_lo, 0); chk({tag, " r3_lo"}, r3_lo, 0);
        chk({tag, " r1_hi"}, r1_hi, 0); chk({tag, " r2_hi"}, r2_hi, 0); chk({tag, " r3_hi"}, r3_hi, 0);
    endtask

    // One allocation. Cycle numbering: start is sampled at edge 0; cycle k is the
    // interval after edge k; sampling happens on the falling edge inside it.
    // kill_cyc != 0 drops rst_n (or raises abort) during cycle kill_cyc.
    task automatic run(input vec_t v, input string tag, input int mid_start,
                       input int c1_cyc, input int kill_cyc, input bit kill_abort);
        vec_t e;
        int   exp_busy, exp_done;
        @(negedge clk);
        n = v.n;
        c1 = v.c[0]; c2 = v.c[1]; c3 = v.c[2]; c4 = v.c[3];
        c5 = v.c[4]; c6 = v.c[5]; c7 = v.c[6];
        start = 1'b1;
        if (kill_cyc == 0) sb.push_back(v);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (kill_cyc != 0) begin
                exp_busy = (cyc <= kill_cyc) ? 1 : 0;
                exp_done = 0;
            end else begin
                exp_busy = (cyc < v.done_cyc) ? 1 : 0;
                exp_done = (cyc == v.done_cyc) ? 1 : 0;
            end
            chk($sformatf("%s busy_lo c%0d", tag, cyc), busy_lo, exp_busy);
            chk($sformatf("%s busy_hi c%0d", tag, cyc), busy_hi, exp_busy);
            chk($sformatf("%s done_lo c%0d", tag, cyc), done_lo, exp_done);
            chk($sformatf("%s done_hi c%0d", tag, cyc), done_hi, exp_done);
            if (kill_cyc == 0 && cyc == v.done_cyc) begin
                if (sb.size() == 0) begin
                    chk({tag, " scoreboard empty"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({tag, " r1_lo"}, r1_lo, e.lo1);
                    chk({tag, " r2_lo"}, r2_lo, e.lo2);
                    chk({tag, " r3_lo"}, r3_lo, e.lo3);
                    chk({tag, " r1_hi"}, r1_hi, e.hi1);
                    chk({tag, " r2_hi"}, r2_hi, e.hi2);
                    chk({tag, " r3_hi"}, r3_hi, e.hi3);
                end
                break;
            end
            if (kill_cyc != 0 && cyc == kill_cyc + 1) begin
                chk_r_zero({tag, " after kill"});
                rst_n = 1'b1;
`ifdef SEAT_ALLOC_ABORT_EN
                abort = 1'b0;
`endif
            end
            if (cyc == c1_cyc) c1 = 4'd0;
            if (mid_start != 0 && cyc == mid_start) start = 1'b1;
            if (mid_start != 0 && cyc == mid_start + 1) start = 1'b0;
            if (kill_cyc != 0 && cyc == kill_cyc) begin
`ifdef SEAT_ALLOC_ABORT_EN
                if (kill_abort) abort = 1'b1;
                else            rst_n = 1'b0;
`else
                rst_n = 1'b0;
`endif
            end
            if (kill_cyc != 0 && cyc >= kill_cyc + 20) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(7,  15,3,7,15,7,4,7,  1,4,3,  4,1,7,  25);
        tbl[1] = mk(15, 15,3,7,15,7,4,7,  1,4,0,  4,1,0,  25);
        tbl[2] = mk(1,  0,0,0,0,0,0,0,    0,0,0,  0,0,0,  9);
        tbl[3] = mk(0,  0,0,0,0,0,0,0,    1,2,3,  7,6,5,  25);
        tbl[4] = mk(0,  0,1,2,3,4,5,6,    7,6,5,  7,6,5,  25);
        tbl[5] = mk(10, 9,12,3,10,2,2,1,  2,4,0,  2,4,0,  25);
        tbl[6] = mk(8,  1,2,3,9,4,5,6,    4,0,0,  4,0,0,  17);
        tbl[7] = mk(15, 0,0,0,0,0,0,15,   7,0,0,  7,0,0,  17);

        rst_n = 1'b0; start = 1'b0;
`ifdef SEAT_ALLOC_ABORT_EN
        abort = 1'b0;
`endif
        n = '0; c1 = '0; c2 = '0; c3 = '0; c4 = '0; c5 = '0; c6 = '0; c7 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy_lo", busy_lo, 0); chk("reset done_lo", done_lo, 0);
        chk("reset busy_hi", busy_hi, 0); chk("reset done_hi", done_hi, 0);
        chk_r_zero("reset");
        rst_n = 1'b1;

        // Table vectors, issued back-to-back (start in the cycle after done).
        for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i), 0, 0, 0, 1'b0);

        // Second start mid-run and a late input change must not disturb the run.
        run(tbl[0], "midstart", 5, 3, 0, 1'b0);

        // Reset mid-run aborts without done; a fresh run then completes.
        run(tbl[0], "rstkill", 0, 0, 12, 1'b0);
        run(tbl[0], "after_rst", 0, 0, 0, 1'b0);

`ifdef SEAT_ALLOC_ABORT_EN
        run(tbl[0], "abortkill", 0, 0, 12, 1'b1);
        run(tbl[5], "after_abort", 0, 0, 0, 1'b0);
`endif

        // Results hold and no further done while idle.
        repeat (4) @(negedge clk);
        chk("hold done_lo", done_lo, 0);
        chk("hold busy_lo", busy_lo, 0);
`ifdef SEAT_ALLOC_ABORT_EN
        chk("hold r1_lo", r1_lo, 2); chk("hold r2_lo", r2_lo, 4); chk("hold r3_lo", r3_lo, 0);
`else
        chk("hold r1_lo", r1_lo, 1); chk("hold r2_lo", r2_lo, 4); chk("hold r3_lo", r3_lo, 3);
        chk("hold r1_hi", r1_hi, 4); chk("hold r2_hi", r2_hi, 1); chk("hold r3_hi", r3_hi, 7);
`endif
        chk("scoreboard drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
